// File: rtl/pulse_train_tx_if.sv
// Request/response bundle for pulse_train_tx: count handshake plus pin and status outputs.
interface pulse_train_tx_if #(
  parameter int CNT_W = 4
);
  logic             start_valid;
  logic [CNT_W-1:0] start_count;
  logic             start_ready;
  logic             pin_out;
  logic             busy;
  logic             done;

  modport master (
    output start_valid, start_count,
    input  start_ready, pin_out, busy, done
  );

  modport slave (
    input  start_valid, start_count,
    output start_ready, pin_out, busy, done
  );
endinterface

// File: rtl/pulse_train_tx.sv
// Drives pin_out with N high/low pulses of fixed length so the button input logic
// sees N presses; a one-cycle done strobe marks the end of each train.
module pulse_train_tx #(
  parameter int HIGH_CYCLES = 160000,
  parameter int LOW_CYCLES  = 160000,
  parameter int CNT_W       = 4
) (
  input  logic CLK,
  input  logic RST,
  pulse_train_tx_if.slave bus
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [TIMER_W-1:0] HIGH_LOAD = TIMER_W'(HIGH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOW_LOAD  = TIMER_W'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t             state;
  state_t             state_next;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   remaining;
  logic               pin_q;
  logic               done_q;
  logic               pin_next;
  logic               done_next;
  logic               accept;
  logic               timer_expired;
  logic               last_pulse;
  logic               idle;

  assign idle          = (state == IDLE);
  assign accept        = idle && bus.start_valid;
  assign timer_expired = (timer == '0);
  assign last_pulse    = (remaining == CNT_W'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && (bus.start_count != '0)) begin
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (timer_expired) begin
          state_next = LOW;
        end
      end
      LOW: begin
        if (timer_expired) begin
          state_next = last_pulse ? IDLE : HIGH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // pin and done are computed one cycle ahead so both leave the block from flops.
  always_comb begin
    pin_next  = (state_next == HIGH);
    done_next = (accept && (bus.start_count == '0)) ||
                ((state == LOW) && timer_expired && last_pulse);
  end

  // Each phase loads length-1 and counts down to zero, so a phase lasts exactly its length.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer     <= '0;
      remaining <= '0;
      pin_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pin_q  <= pin_next;
      done_q <= done_next;
      case (state)
        IDLE: begin
          if (accept) begin
            remaining <= bus.start_count;
            timer     <= HIGH_LOAD;
          end
        end
        HIGH: begin
          timer <= timer_expired ? LOW_LOAD : timer - TIMER_W'(1);
        end
        LOW: begin
          if (timer_expired) begin
            if (remaining != '0) begin
              remaining <= remaining - CNT_W'(1);
            end
            timer <= HIGH_LOAD;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        default: begin
          timer     <= '0;
          remaining <= '0;
        end
      endcase
    end
  end

  assign bus.start_ready = idle;
  assign bus.busy        = !idle;
  assign bus.pin_out     = pin_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_pulse_train_tx.sv
// Directed bench for pulse_train_tx: stimulus queues expected trains, a negedge
// monitor pops them on each done strobe and checks latency, pulse count and widths.
module tb_pulse_train_tx;

  localparam int HIGH_CYCLES = 3;
  localparam int LOW_CYCLES  = 2;
  localparam int CNT_W       = 4;

  typedef struct {
    int pulses;
    int latency;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  int   sinceAccept = 1000;
  int   pulseCount  = 0;
  logic prevPin     = 1'b0;
  int   runLen      = 0;

  pulse_train_tx_if #(.CNT_W(CNT_W)) bus ();

  pulse_train_tx #(
    .HIGH_CYCLES(HIGH_CYCLES),
    .LOW_CYCLES (LOW_CYCLES),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Monitor: samples on negedge, matches each done strobe with the oldest queued train.
  always @(negedge CLK) begin
    if (RST) begin
      sinceAccept = 1000;
      pulseCount  = 0;
      prevPin     = 1'b0;
      runLen      = 0;
    end else begin
      checks++;
      if (bus.busy !== !bus.start_ready) begin
        errors++;
        $display("[TB] FAIL busy_vs_ready: busy=%b start_ready=%b", bus.busy, bus.start_ready);
      end
      sinceAccept++;
      if (bus.pin_out !== prevPin) begin
        if (prevPin === 1'b1) begin
          checks++;
          if (runLen != HIGH_CYCLES) begin
            errors++;
            $display("[TB] FAIL high_width: got %0d cycles, want %0d", runLen, HIGH_CYCLES);
          end
        end else begin
          pulseCount++;
        end
        runLen = 1;
      end else begin
        runLen++;
      end
      prevPin = bus.pin_out;
      if (bus.done === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1, want no done at t=%0t", $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          if (sinceAccept != e.latency) begin
            errors++;
            $display("[TB] FAIL done_latency: got %0d, want %0d", sinceAccept, e.latency);
          end
          checks++;
          if (pulseCount != e.pulses) begin
            errors++;
            $display("[TB] FAIL pulse_count: got %0d, want %0d", pulseCount, e.pulses);
          end
        end
      end
      if (bus.start_valid && bus.start_ready) begin
        sinceAccept = 0;
        pulseCount  = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic expPin, input logic expReady,
                             input logic expBusy, input logic expDone);
    logic [3:0] got;
    logic [3:0] want;
    got  = {bus.pin_out, bus.start_ready, bus.busy, bus.done};
    want = {expPin, expReady, expBusy, expDone};
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got pin/ready/busy/done=%b, want %b", name, got, want);
    end
  endtask

  // Issues a one-cycle request; returns #1 after the accepting edge.
  task automatic applyStimulus(input int n);
    exp_t e;
    @(posedge CLK);
    #1;
    bus.start_valid = 1'b1;
    bus.start_count = CNT_W'(n);
    e.pulses  = n;
    e.latency = (n == 0) ? 1 : n * (HIGH_CYCLES + LOW_CYCLES) + 1;
    expQ.push_back(e);
    @(posedge CLK);
    #1;
    bus.start_valid = 1'b0;
    bus.start_count = '0;
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 200 && expQ.size() != 0; i++) begin
      @(negedge CLK);
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d trains outstanding, want 0", name, expQ.size());
      expQ.delete();
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t e;
    bus.start_valid = 1'b0;
    bus.start_count = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_state", 1'b0, 1'b1, 1'b0, 1'b0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("post_reset_idle", 1'b0, 1'b1, 1'b0, 1'b0);

    applyStimulus(1);
    checkOutput("n1_first_high", 1'b1, 1'b0, 1'b1, 1'b0);
    waitIdle("n1");

    RST = 1'b1;
    #2;
    checkOutput("idle_reset_async", 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("idle_reset_release", 1'b0, 1'b1, 1'b0, 1'b0);

    applyStimulus(3);
    waitIdle("n3");

    applyStimulus(0);
    checkOutput("n0_done_cycle", 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    checkOutput("n0_after_done", 1'b0, 1'b1, 1'b0, 1'b0);
    waitIdle("n0");

    // Held request during a train must wait for the done cycle, then chain.
    @(posedge CLK);
    #1;
    bus.start_valid = 1'b1;
    bus.start_count = CNT_W'(1);
    e.pulses  = 1;
    e.latency = HIGH_CYCLES + LOW_CYCLES + 1;
    expQ.push_back(e);
    e.pulses  = 2;
    e.latency = 2 * (HIGH_CYCLES + LOW_CYCLES) + 1;
    expQ.push_back(e);
    @(posedge CLK);
    #1;
    bus.start_count = CNT_W'(2);
    for (int i = 0; i < 50 && bus.done !== 1'b1; i++) begin
      @(negedge CLK);
    end
    checkOutput("chain_done_ready", 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    bus.start_valid = 1'b0;
    bus.start_count = '0;
    checkOutput("chain_next_high", 1'b1, 1'b0, 1'b1, 1'b0);
    waitIdle("chain");

    applyStimulus(4);
    repeat (6) @(posedge CLK);
    #1;
    checkOutput("n4_second_high", 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("midtrain_reset_async", 1'b0, 1'b1, 1'b0, 1'b0);
    expQ.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checkOutput("after_reset_quiet", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
